avmm_cmd_master: RTL and testbench

- Avalon-MM master that issues single register reads and writes to memory-mapped control slaves, such as the 26-bit r_change_on_off-style control registers, on behalf of an internal sequencer.
- Accepts one command at a time over a valid/ready interface.
- Drives the Avalon-MM transfer, honouring waitrequest and readdatavalid.
- Returns a response carrying the read data and a timeout error flag.

---
 rtl/avmm_cmd_master.sv | 152 +++++++++++++++
 tb/tb_avmm_cmd_master.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/avmm_cmd_master.sv
`default_nettype none
// avmm_cmd_master: single-outstanding Avalon-MM register master with a valid/ready
// command/response front end and a per-phase bus-wait timeout.
module avmm_cmd_master #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_address,
  input  logic [DATA_W-1:0] cmd_writedata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_readdata,
  output logic              rsp_error,
  output logic              busy,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  output logic              avm_write,
  output logic [DATA_W-1:0] avm_writedata,
  input  logic              avm_waitrequest,
  input  logic [DATA_W-1:0] avm_readdata,
  input  logic              avm_readdatavalid
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] c_timeout_cnt = CNT_W'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WRITE   = 3'd1,
    S_RD_REQ  = 3'd2,
    S_RD_WAIT = 3'd3,
    S_RESP    = 3'd4
  } state_t;

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              cmd_ready_q;
  logic              rsp_valid_q;
  logic [DATA_W-1:0] rsp_readdata_q;
  logic              rsp_error_q;
  logic              busy_q;
  logic [ADDR_W-1:0] avm_address_q;
  logic              avm_read_q;
  logic              avm_write_q;
  logic [DATA_W-1:0] avm_writedata_q;
  logic              tmo_hit;

  // The counter stops at TIMEOUT because every state that counts leaves on a hit.
  assign tmo_hit = (cnt_q == c_timeout_cnt);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q         <= S_IDLE;
      cnt_q           <= '0;
      cmd_ready_q     <= 1'b0;
      rsp_valid_q     <= 1'b0;
      rsp_readdata_q  <= '0;
      rsp_error_q     <= 1'b0;
      busy_q          <= 1'b0;
      avm_address_q   <= '0;
      avm_read_q      <= 1'b0;
      avm_write_q     <= 1'b0;
      avm_writedata_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          cmd_ready_q <= 1'b1;
          if (cmd_valid && cmd_ready_q) begin
            cmd_ready_q     <= 1'b0;
            busy_q          <= 1'b1;
            avm_address_q   <= cmd_address;
            avm_writedata_q <= cmd_writedata;
            cnt_q           <= '0;
            if (cmd_write) begin
              avm_write_q <= 1'b1;
              state_q     <= S_WRITE;
            end else begin
              avm_read_q <= 1'b1;
              state_q    <= S_RD_REQ;
            end
          end
        end
        S_WRITE: begin
          // Acceptance beats a same-cycle timeout.
          if (!avm_waitrequest || tmo_hit) begin
            avm_write_q    <= 1'b0;
            rsp_valid_q    <= 1'b1;
            rsp_readdata_q <= '0;
            rsp_error_q    <= avm_waitrequest;
            state_q        <= S_RESP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_RD_REQ: begin
          if (!avm_waitrequest) begin
            avm_read_q <= 1'b0;
            cnt_q      <= '0;
            state_q    <= S_RD_WAIT;
          end else if (tmo_hit) begin
            avm_read_q     <= 1'b0;
            rsp_valid_q    <= 1'b1;
            rsp_readdata_q <= '0;
            rsp_error_q    <= 1'b1;
            state_q        <= S_RESP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_RD_WAIT: begin
          if (avm_readdatavalid || tmo_hit) begin
            rsp_valid_q    <= 1'b1;
            rsp_readdata_q <= avm_readdatavalid ? avm_readdata : '0;
            rsp_error_q    <= !avm_readdatavalid;
            state_q        <= S_RESP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            cmd_ready_q <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign cmd_ready     = cmd_ready_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_readdata  = rsp_readdata_q;
  assign rsp_error     = rsp_error_q;
  assign busy          = busy_q;
  assign avm_address   = avm_address_q;
  assign avm_read      = avm_read_q;
  assign avm_write     = avm_write_q;
  assign avm_writedata = avm_writedata_q;

endmodule
`default_nettype wire

// File: tb/tb_avmm_cmd_master.sv
`default_nettype none
// Bench for avmm_cmd_master: two instances (TIMEOUT 8 and 4) share one slave model;
// sel routes the command valid and the observed outputs to one of them.
module tb_avmm_cmd_master;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;
  localparam int TO_A   = 8;
  localparam int TO_B   = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset_n;
  logic              sel;
  logic              cmd_valid, cmd_write, rsp_ready;
  logic [ADDR_W-1:0] cmd_address;
  logic [DATA_W-1:0] cmd_writedata;
  logic              avm_waitrequest, avm_readdatavalid;
  logic [DATA_W-1:0] avm_readdata;

  logic              cmd_valid_a, cmd_valid_b;
  assign cmd_valid_a = cmd_valid & ~sel;
  assign cmd_valid_b = cmd_valid & sel;

  logic              a_cmd_ready, a_rsp_valid, a_rsp_error, a_busy, a_avm_read, a_avm_write;
  logic [DATA_W-1:0] a_rsp_readdata, a_avm_writedata;
  logic [ADDR_W-1:0] a_avm_address;
  logic              b_cmd_ready, b_rsp_valid, b_rsp_error, b_busy, b_avm_read, b_avm_write;
  logic [DATA_W-1:0] b_rsp_readdata, b_avm_writedata;
  logic [ADDR_W-1:0] b_avm_address;

  avmm_cmd_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TO_A)) u_dut_a (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid_a), .cmd_ready(a_cmd_ready), .cmd_write(cmd_write),
    .cmd_address(cmd_address), .cmd_writedata(cmd_writedata),
    .rsp_valid(a_rsp_valid), .rsp_ready(rsp_ready), .rsp_readdata(a_rsp_readdata),
    .rsp_error(a_rsp_error), .busy(a_busy),
    .avm_address(a_avm_address), .avm_read(a_avm_read), .avm_write(a_avm_write),
    .avm_writedata(a_avm_writedata), .avm_waitrequest(avm_waitrequest),
    .avm_readdata(avm_readdata), .avm_readdatavalid(avm_readdatavalid)
  );

  avmm_cmd_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TO_B)) u_dut_b (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid_b), .cmd_ready(b_cmd_ready), .cmd_write(cmd_write),
    .cmd_address(cmd_address), .cmd_writedata(cmd_writedata),
    .rsp_valid(b_rsp_valid), .rsp_ready(rsp_ready), .rsp_readdata(b_rsp_readdata),
    .rsp_error(b_rsp_error), .busy(b_busy),
    .avm_address(b_avm_address), .avm_read(b_avm_read), .avm_write(b_avm_write),
    .avm_writedata(b_avm_writedata), .avm_waitrequest(avm_waitrequest),
    .avm_readdata(avm_readdata), .avm_readdatavalid(avm_readdatavalid)
  );

  logic              o_cmd_ready, o_rsp_valid, o_rsp_error, o_busy, o_avm_read, o_avm_write;
  logic [DATA_W-1:0] o_rsp_readdata, o_avm_writedata;
  logic [ADDR_W-1:0] o_avm_address;
  assign o_cmd_ready     = sel ? b_cmd_ready     : a_cmd_ready;
  assign o_rsp_valid     = sel ? b_rsp_valid     : a_rsp_valid;
  assign o_rsp_error     = sel ? b_rsp_error     : a_rsp_error;
  assign o_busy          = sel ? b_busy          : a_busy;
  assign o_avm_read      = sel ? b_avm_read      : a_avm_read;
  assign o_avm_write     = sel ? b_avm_write     : a_avm_write;
  assign o_rsp_readdata  = sel ? b_rsp_readdata  : a_rsp_readdata;
  assign o_avm_writedata = sel ? b_avm_writedata : a_avm_writedata;
  assign o_avm_address   = sel ? b_avm_address   : a_avm_address;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One complete transfer. ws = waitrequest cycles before acceptance, lat = cycles
  // from acceptance to readdatavalid, rdly = cycles rsp_ready is held low.
  task automatic do_txn(input logic s, input logic wr, input logic [ADDR_W-1:0] addr,
                        input logic [DATA_W-1:0] wdata, input int ws, input int lat,
                        input logic [DATA_W-1:0] rdata, input int rdly, input logic stray);
    int tmo, n, idx, k, exp_req, exp_wait;
    logic req_ok, data_ok, exp_err;
    logic [DATA_W-1:0] exp_rd;
    logic [1:0] kind;
    tmo      = s ? TO_B : TO_A;
    // Reference: a phase lasting more than TIMEOUT+1 cycles is cut off at TIMEOUT+1.
    req_ok   = (ws <= tmo);
    exp_req  = req_ok ? ws + 1 : tmo + 1;
    data_ok  = wr || (lat - 1 <= tmo);
    exp_err  = !(req_ok && data_ok);
    exp_rd   = (!wr && !exp_err) ? rdata : '0;
    exp_wait = (wr || !req_ok) ? 0 : (data_ok ? lat : tmo + 1);
    kind     = wr ? 2'b01 : 2'b10;
    sel = s;
    n = 0;
    while (o_cmd_ready !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    check("cmd_ready_idle", 64'(o_cmd_ready), 64'(1));
    cmd_valid = 1'b1; cmd_write = wr; cmd_address = addr; cmd_writedata = wdata;
    step();
    cmd_valid = 1'b0;
    cmd_write = 1'($urandom); cmd_address = 8'($urandom); cmd_writedata = $urandom;
    check("accept_busy_ready", 64'({o_busy, o_cmd_ready}), 64'(2'b10));
    check("req_kind_first", 64'({o_avm_read, o_avm_write}), 64'(kind));
    idx = 0;
    while ((o_avm_read || o_avm_write) && idx < tmo + 4) begin
      check("req_kind", 64'({o_avm_read, o_avm_write}), 64'(kind));
      check("req_addr", 64'(o_avm_address), 64'(addr));
      if (wr) check("req_wdata", 64'(o_avm_writedata), 64'(wdata));
      avm_waitrequest = (idx < ws);
      step();
      idx++;
    end
    avm_waitrequest = 1'($urandom);
    check("req_cycles", 64'(idx), 64'(exp_req));
    k = 0;
    while (o_rsp_valid !== 1'b1 && k < tmo + 4) begin
      avm_readdatavalid = (k == lat - 1);
      avm_readdata      = (k == lat - 1) ? rdata : $urandom;
      step();
      k++;
    end
    avm_readdatavalid = 1'b0;
    check("wait_cycles", 64'(k), 64'(exp_wait));
    check("rsp_valid", 64'(o_rsp_valid), 64'(1));
    check("rsp_error", 64'(o_rsp_error), 64'(exp_err));
    check("rsp_readdata", 64'(o_rsp_readdata), 64'(exp_rd));
    check("rsp_cmd_ready", 64'(o_cmd_ready), 64'(0));
    for (int i = 0; i < rdly; i++) begin
      rsp_ready = 1'b0;
      if (stray && i == 0) begin
        avm_readdatavalid = 1'b1;
        avm_readdata      = $urandom;
      end
      step();
      avm_readdatavalid = 1'b0;
      check("bp_valid", 64'(o_rsp_valid), 64'(1));
      check("bp_data", 64'(o_rsp_readdata), 64'(exp_rd));
      check("bp_error", 64'(o_rsp_error), 64'(exp_err));
      check("bp_cmd_ready", 64'({o_cmd_ready, o_busy}), 64'(2'b01));
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'($urandom);
    check("post_handshake", 64'({o_rsp_valid, o_cmd_ready, o_busy}), 64'(3'b010));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; sel = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; rsp_ready = 1'b0;
    cmd_address = '0; cmd_writedata = '0;
    avm_waitrequest = 1'b0; avm_readdatavalid = 1'b0; avm_readdata = '0;
    step(); step();
    check("reset_ctl_a", 64'({a_cmd_ready, a_rsp_valid, a_rsp_error, a_busy, a_avm_read, a_avm_write}), 64'(0));
    check("reset_data_a", {a_rsp_readdata, a_avm_writedata}, 64'(0));
    check("reset_addr_a", 64'(a_avm_address), 64'(0));
    check("reset_ctl_b", 64'({b_cmd_ready, b_rsp_valid, b_busy, b_avm_read, b_avm_write}), 64'(0));
    reset_n = 1'b1;
    step();

    // Directed cases
    do_txn(1'b0, 1'b1, 8'h00, 32'h03FF_FFFF, 0, 1, 32'h0, 0, 1'b0);
    do_txn(1'b0, 1'b0, 8'h24, 32'h0, 3, 2, 32'h0012_3456, 0, 1'b0);
    do_txn(1'b0, 1'b0, 8'h31, 32'h0, 1000, 1, 32'hDEAD_BEEF, 2, 1'b1);
    avm_readdatavalid = 1'b1; avm_readdata = 32'hBAD0_0BAD;
    step();
    avm_readdatavalid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("stray_no_rsp", 64'({o_rsp_valid, o_busy, o_cmd_ready}), 64'(3'b001));
      step();
    end
    do_txn(1'b0, 1'b0, 8'h42, 32'h0, 1, 1, 32'hCAFE_F00D, 5, 1'b0);
    do_txn(1'b0, 1'b1, 8'h43, 32'h1234_5678, 2, 1, 32'h0, 5, 1'b0);

    // Reset while waiting for read data
    sel = 1'b0;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_address = 8'h55; cmd_writedata = 32'hA5A5_A5A5;
    step();
    cmd_valid = 1'b0;
    avm_waitrequest = 1'b0;
    step();
    check("rdwait_before_reset", 64'({o_busy, o_avm_read, o_rsp_valid}), 64'(3'b100));
    reset_n = 1'b0;
    step();
    check("midreset_ctl", 64'({a_cmd_ready, a_rsp_valid, a_rsp_error, a_busy, a_avm_read, a_avm_write}), 64'(0));
    check("midreset_data", {a_rsp_readdata, a_avm_writedata}, 64'(0));
    check("midreset_addr", 64'(a_avm_address), 64'(0));
    reset_n = 1'b1;
    avm_readdatavalid = 1'b1; avm_readdata = 32'h7777_7777;
    step();
    avm_readdatavalid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("after_reset_no_rsp", 64'({o_rsp_valid, o_busy}), 64'(0));
      step();
    end
    do_txn(1'b0, 1'b1, 8'h66, 32'h0BAD_F00D, 0, 1, 32'h0, 1, 1'b0);

    // TIMEOUT = 4 instance: exit in the timeout cycle wins, one later loses
    do_txn(1'b1, 1'b0, 8'h10, 32'h0, 4, 1, 32'h0ABC_DEF0, 0, 1'b0);
    do_txn(1'b1, 1'b1, 8'h11, 32'h1111_2222, 4, 1, 32'h0, 0, 1'b0);
    do_txn(1'b1, 1'b1, 8'h12, 32'h3333_4444, 5, 1, 32'h0, 0, 1'b0);
    do_txn(1'b1, 1'b0, 8'h13, 32'h0, 0, 5, 32'h5555_6666, 0, 1'b0);
    do_txn(1'b1, 1'b0, 8'h14, 32'h0, 0, 6, 32'h7777_8888, 1, 1'b1);

    // Randomized transfers on both instances
    for (int t = 0; t < 40; t++) begin
      do_txn(1'($urandom), 1'($urandom), 8'($urandom), $urandom,
             int'($urandom_range(0, 10)), int'($urandom_range(1, 11)), $urandom,
             int'($urandom_range(0, 3)), 1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
